// File: rtl/countdown_timer6.sv
// Loadable, pausable down-counter with prescaler and one-cycle terminal-count pulse.
// Optional periodic mode: define COUNTDOWN_AUTO_RELOAD_EN to reload from the last loaded value at terminal count.
module countdown_timer6 #(
    parameter int WIDTH    = 6,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    // state | meaning
    // IDLE  | not counting; start launches a run (or pulses done if count is 0)
    // RUN   | prescaler advancing, count decrements every PRESCALE cycles
    // PAUSE | count and prescaler frozen until start
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            presc_d  = '0;
            state_d  = IDLE;
        end else if (stop) begin
            // The stop edge itself does not advance the prescaler or count.
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count_q != '0) begin
                            state_d = RUN;
                            presc_d = '0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (count_q <= WIDTH'(1)) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (reload_q != '0) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                            end
`else
                            count_d = '0;
                            state_d = IDLE;
`endif
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign zero  = (count_q == '0);

endmodule
